// File: rtl/display_arbiter.sv
// display_arbiter: shares the 8-digit tube datapath among four pages
// (0 = clock, 1 = countdown, 2 = working timer, 3 = alert).
// The highest-priority request wins. A newly granted page keeps the display
// for a minimum hold time, unless its own request drops first.
// The winner's nibble data is registered toward timeDisplay.
// Optional feature macro: BLINK_EN enables per-digit blinking through
// blink_mask. When BLINK_EN is undefined, blink_mask is ignored and no
// phase counter exists.
module display_arbiter #(
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter int         BLINK_HALF  = 25_000_000,
    parameter logic [3:0] BLANK_CODE  = 4'hE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] page_data,
    input  logic [31:0]  blink_mask,
    input  logic         lock,
    output logic [31:0]  time_data,
    output logic [3:0]   grant,
    output logic         page_changed
);

    typedef enum logic {FREE = 1'b0, HOLD = 1'b1} state_t;

    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);

    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          page_changed_q, page_changed_d;
    logic [31:0]   time_data_q, time_data_d;

    logic [3:0]    ereq;
    logic [1:0]    win_idx;
    logic [3:0]    win_onehot;
    logic [1:0]    owner_idx;
    logic          owner_req;

    // Fixed-priority winner over the effective requests; the clock page always requests
    always_comb begin
        ereq    = {req[3:1], 1'b1};
        win_idx = 2'd0;
        if (ereq[1]) win_idx = 2'd1;
        if (ereq[2]) win_idx = 2'd2;
        if (ereq[3]) win_idx = 2'd3;
        win_onehot = 4'b0001 << win_idx;
    end

    // Encode the one-hot owner and check whether it is still requesting
    always_comb begin
        owner_idx = 2'd0;
        case (grant_q)
            4'b0010: owner_idx = 2'd1;
            4'b0100: owner_idx = 2'd2;
            4'b1000: owner_idx = 2'd3;
            default: owner_idx = 2'd0;
        endcase
        owner_req = |(ereq & grant_q);
    end

    // Arbitration FSM: HOLD protects a fresh owner, FREE allows replacement
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            HOLD: begin
                if (!owner_req) begin
                    // Owner released; restart the hold for the next owner.
                    grant_d    = win_onehot;
                    hold_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + CW'(1);
                    if (hold_cnt_q == HOLD_LAST) state_d = FREE;
                end
            end
            FREE: begin
                if (lock && owner_req) begin
                    state_d = FREE;
                end else if (win_onehot != grant_q) begin
                    grant_d    = win_onehot;
                    hold_cnt_d = '0;
                    state_d    = (HOLD_CYCLES == 0) ? FREE : HOLD;
                end
            end
            default: state_d = FREE;
        endcase
        page_changed_d = (grant_d != grant_q);
    end

`ifdef BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // Free-running blink phase; restarts visible on every grant change
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (grant_d != grant_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // Owner data with blinking digits blanked during the dark phase
    always_comb begin
        time_data_d = page_data[{owner_idx, 5'd0} +: 32];
        for (int k = 0; k < 8; k++) begin
            if (phase_q && blink_mask[{owner_idx, 3'(k)}]) begin
                time_data_d[4*k +: 4] = BLANK_CODE;
            end
        end
    end

    // Blink phase registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    logic unused_inputs;
    assign unused_inputs = req[0];
`else
    // Owner data passes straight through to the output register
    always_comb begin
        time_data_d = page_data[{owner_idx, 5'd0} +: 32];
    end

    logic unused_inputs;
    assign unused_inputs = ^{req[0], blink_mask, BLANK_CODE, BLINK_HALF[0]};
`endif

    // State, grant, hold counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FREE;
            grant_q        <= 4'b0001;
            hold_cnt_q     <= '0;
            page_changed_q <= 1'b0;
            time_data_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            hold_cnt_q     <= hold_cnt_d;
            page_changed_q <= page_changed_d;
            time_data_q    <= time_data_d;
        end
    end

    assign grant        = grant_q;
    assign page_changed = page_changed_q;
    assign time_data    = time_data_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with HOLD_CYCLES=4 and BLINK_HALF=3.
// It applies a table of per-cycle vectors, then runs hand sequences for
// reset during a hold and for blinking. When BLINK_EN is undefined, the
// blink sequence checks that blink_mask is ignored.
module tb_display_arbiter;

    localparam logic [31:0] P0 = 32'h12F34F56;
    localparam logic [31:0] P1 = 32'h11111111;
    localparam logic [31:0] P2 = 32'h22222222;
    localparam logic [31:0] P3 = 32'h33333333;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] page_data;
    logic [31:0]  blink_mask;
    logic         lock;
    logic [31:0]  time_data;
    logic [3:0]   grant;
    logic         page_changed;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic        lock;
        logic [3:0]  exp_grant;
        logic        exp_pc;
        logic [31:0] exp_td;
    } vec_t;

    vec_t vq[$];

    display_arbiter #(
        .HOLD_CYCLES (4),
        .BLINK_HALF  (3),
        .BLANK_CODE  (4'hE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .page_data    (page_data),
        .blink_mask   (blink_mask),
        .lock         (lock),
        .time_data    (time_data),
        .grant        (grant),
        .page_changed (page_changed)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] r, input logic l, input logic [3:0] g,
                           input logic pc, input logic [31:0] td);
        vec_t v;
        v.req       = r;
        v.lock      = l;
        v.exp_grant = g;
        v.exp_pc    = pc;
        v.exp_td    = td;
        vq.push_back(v);
    endtask

    initial begin
        //            req      lock  grant    pc    time_data
        add_vec(4'b0100, 1'b0, 4'b0100, 1'b1, P0); // FREE: req2 wins
        add_vec(4'b1100, 1'b0, 4'b0100, 1'b0, P2); // hold 0 -> 1, alert waits
        add_vec(4'b1100, 1'b0, 4'b0100, 1'b0, P2); // hold 2
        add_vec(4'b1100, 1'b0, 4'b0100, 1'b0, P2); // hold 3
        add_vec(4'b1100, 1'b0, 4'b0100, 1'b0, P2); // -> FREE
        add_vec(4'b1100, 1'b0, 4'b1000, 1'b1, P2); // alert takes over
        add_vec(4'b1100, 1'b0, 4'b1000, 1'b0, P3);
        add_vec(4'b0100, 1'b0, 4'b0100, 1'b1, P3); // alert releases during hold
        add_vec(4'b0110, 1'b0, 4'b0100, 1'b0, P2); // hold cycle 1
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b1, P2); // owner 2 drops -> page 1
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b0, P1); // -> FREE
        add_vec(4'b1010, 1'b1, 4'b0010, 1'b0, P1); // lock blocks alert
        add_vec(4'b1010, 1'b1, 4'b0010, 1'b0, P1);
        add_vec(4'b1010, 1'b0, 4'b1000, 1'b1, P1); // lock dropped
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b1, P3); // alert releases
        add_vec(4'b0010, 1'b1, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b1, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b1, 4'b0010, 1'b0, P1);
        add_vec(4'b0010, 1'b1, 4'b0010, 1'b0, P1); // -> FREE
        add_vec(4'b0000, 1'b1, 4'b0001, 1'b1, P1); // release honoured under lock
        add_vec(4'b0000, 1'b1, 4'b0001, 1'b0, P0);
        add_vec(4'b0010, 1'b0, 4'b0001, 1'b0, P0); // page 0 held
        add_vec(4'b0010, 1'b0, 4'b0001, 1'b0, P0);
        add_vec(4'b0010, 1'b0, 4'b0001, 1'b0, P0); // -> FREE
        add_vec(4'b0010, 1'b0, 4'b0010, 1'b1, P0);
        add_vec(4'b1000, 1'b0, 4'b1000, 1'b1, P1); // drop + higher req together
        add_vec(4'b1000, 1'b0, 4'b1000, 1'b0, P3);

        // reset
        rst        = 1'b0;
        req        = 4'b0000;
        lock       = 1'b0;
        blink_mask = 32'd0;
        page_data  = {P3, P2, P1, P0};
        step();
        step();
        check("reset_grant", {28'd0, grant}, 32'h1);
        check("reset_td", time_data, 32'd0);
        check("reset_pc", {31'd0, page_changed}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("post_reset_grant", {28'd0, grant}, 32'h1);
            check("post_reset_pc", {31'd0, page_changed}, 32'd0);
        end
        check("post_reset_td", time_data, P0);

        // table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            req  = vq[i].req;
            lock = vq[i].lock;
            step();
            check($sformatf("vec%0d_grant", i), {28'd0, grant}, {28'd0, vq[i].exp_grant});
            check($sformatf("vec%0d_pc", i), {31'd0, page_changed}, {31'd0, vq[i].exp_pc});
            check($sformatf("vec%0d_td", i), time_data, vq[i].exp_td);
        end

        // asynchronous reset while the alert page is in HOLD
        #2;
        rst = 1'b0;
        #1;
        check("midrst_grant", {28'd0, grant}, 32'h1);
        check("midrst_td", time_data, 32'd0);
        check("midrst_pc", {31'd0, page_changed}, 32'd0);
        req = 4'b1000;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rearb_grant", {28'd0, grant}, 32'h8);
        check("rearb_pc", {31'd0, page_changed}, 32'd1);
        check("rearb_td", time_data, P0);
        step();
        check("rearb2_pc", {31'd0, page_changed}, 32'd0);
        check("rearb2_td", time_data, P3);

        // blink sequence on page 0
        rst       = 1'b0;
        req       = 4'b0000;
        page_data = {P3, P2, P1, 32'h00000059};
`ifdef BLINK_EN
        blink_mask = 32'h00000003;
`else
        blink_mask = 32'hFFFFFFFF;
`endif
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            logic [31:0] exp_td;
            step();
            exp_td = 32'h00000059;
`ifdef BLINK_EN
            if ((((i - 1) / 3) % 2) == 1) exp_td = 32'h000000EE;
`endif
            check($sformatf("blink%0d_td", i), time_data, exp_td);
            check($sformatf("blink%0d_grant", i), {28'd0, grant}, 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit tube datapath (timeDisplay time_data input) among four page requesters: clock page, countdown page, working-timer page and alert page.
- Picks one owner by fixed priority, with a minimum hold time so pages do not flicker.
- Registers the owner's 32-bit nibble-coded data toward timeDisplay and reports which page is visible.

Parameters:
- HOLD_CYCLES, 50_000_000, minimum cycles a newly granted page keeps the display (0.5 s at 100 MHz); 0 = no hold.
- BLINK_HALF, 25_000_000, half-period of the blink toggle, in cycles (only used with BLINK_EN).
- BLANK_CODE, 4'hE, nibble code substituted for blanked digits (only used with BLINK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  4  level requests; bit 3 = highest priority (alert), bit 0 = clock page; bit 0 is treated as always 1
- page_data  in  128  packed nibble data; requester i on bits [32i+31:32i], same format as timeDisplay time_data
- blink_mask  in  32  8 bits per requester, bit k blinks digit k of that requester's data (used only with BLINK_EN)
- lock  in  1  while high, no preemption; owner-release still honoured
- time_data  out  32  registered data of current owner toward timeDisplay
- grant  out  4  one-hot current owner
- page_changed  out  1  one-cycle pulse in the cycle grant takes a new value

Behaviour:
- Reset (rst low, async): grant=4'b0001, time_data=32'd0, page_changed=0, hold counter=0, state=FREE, blink phase=0.
- Effective request: ereq = {req[3:1],1'b1}. Winner = highest set bit of ereq.
- States:
  - HOLD: counter increments each cycle.
  - FREE: owner may be replaced.
- HOLD transitions:
  - Owner's ereq bit drops → release: grant<=winner, counter<=0, stay HOLD, page_changed=1.
  - Else counter==HOLD_CYCLES-1 → FREE.
  - Otherwise grant unchanged, even if a higher req rises.
- FREE transitions:
  - lock high and owner still requesting → no change.
  - Else winner != owner → grant<=winner, counter<=0, state<=HOLD (or stay FREE if HOLD_CYCLES==0), page_changed=1.
  - Else no change.
- Simultaneous owner drop and higher request in the same cycle: winner is computed from the current ereq, so the higher request wins.
- Owner 0 can never release, since req[0] is forced.
- Grant latency: a request seen at edge n updates grant at edge n+1.
- time_data latency: registered from page_data of the new grant one edge later. Data always follows the current grant register, so a switch shows new data at n+2.
- page_changed is high only in the cycle where grant differs from the previous cycle's grant.
- Hold counter width: $clog2(HOLD_CYCLES+1); saturates and never wraps.
- Reset mid-hold: returns to grant 0001 immediately. The first cycle after reset release re-arbitrates as FREE.

Optional Feature:
- Macro BLINK_EN.
- Defined:
  - Free-running phase counter toggles a blink phase every BLINK_HALF cycles.
  - While phase=1, each time_data nibble k whose blink_mask bit (8·owner+k) is set is replaced by BLANK_CODE.
  - The phase counter resets to 0 on every grant change, so a new page starts visible.
- Undefined: blink_mask is ignored and time_data is a pure registered copy of the owner's data; no phase counter is synthesized.

Test Plan (HOLD_CYCLES=4, BLINK_HALF=3):
- Reset, req=4'b0000, page0=32'h12F34F56 → grant=0001, time_data=32'h12F34F56 two cycles after rst rises; page_changed never pulses.
- From FREE on page 0, raise req[2] → grant=0100 one edge later, page_changed pulses once; raise req[3] the next cycle → grant stays 0100 for 4 cycles, then 1000 with one pulse.
- Owner 2 in HOLD drops req[2] at hold cycle 1 while req[1]=1 → grant=0010 next edge, counter restarts.
- lock=1 with owner 1 in FREE, raise req[3] → grant stays 0010; drop lock → grant=1000 next edge.
- Owner 1 drops req while lock=1 → grant falls to 0001 (release honoured despite lock).
- BLINK_EN, owner 0, blink_mask[1:0]=2'b11, page0=32'h00000059 → low two nibbles alternate 59 / EE every 3 cycles, other nibbles unchanged.
